cla_seq_adder32: RTL and testbench
==================================

# cla_seq_adder32

Multi-cycle 32-bit add/subtract unit for the MIPS_Archi ALU path. It reuses a single `CLA_8bit` instance and processes one byte per clock, least-significant byte first. A registered carry links each byte to the next. A start/busy/done handshake lets the ALU control FSM issue an operation and collect the sum, carry, signed-overflow and zero flags.

## Interface
Parameters:
- `WIDTH`, default 32: operand width. Must be a multiple of 8.
- `NBYTES`, default `WIDTH/8`: derived value, not overridden.

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: operation request, sampled on the rising edge.
- `A`, in, WIDTH: operand A, latched when `start` is accepted.
- `B`, in, WIDTH: operand B, latched when `start` is accepted.
- `Cin`, in, 1: carry-in for add; ignored when `sub`=1.
- `sub`, in, 1: 1 selects A − B (A + ~B + 1). Latched with the operands.
- `busy`, out, 1: high while bytes are being processed.
- `done`, out, 1: one-cycle pulse when the result is valid.
- `S`, out, WIDTH: result.
- `Cout`, out, 1: carry out of the MSB byte.
- `ovf`, out, 1: two's-complement signed overflow.
- `zero`, out, 1: high when `S` == 0.

## Operation
- State machine states: IDLE, RUN, DONE.
  - IDLE → RUN when `start`=1.
  - RUN stays in RUN while the byte index is below NBYTES−1.
  - RUN → DONE on the last byte.
  - DONE → RUN if `start`=1 (back-to-back operation); otherwise DONE → IDLE.
- On accept (`start` in IDLE or DONE):
  - Latch `A` into opA.
  - Latch `B` into opB, XORed with {WIDTH{sub}}.
  - Carry register ← `sub` ? 1 : `Cin`.
  - Byte index ← 0.
- Each RUN cycle, `CLA_8bit` is fed opA[8i+7:8i], opB[8i+7:8i] and the carry register:
  - The sum byte is written into the internal accumulator at byte i.
  - Carry register ← CLA `Cout`.
  - Index increments.
  - The `PG`/`GG` outputs of `CLA_8bit` are unused.
- On the edge entering DONE, the output registers update together:
  - `S` ← accumulator with the final byte merged in.
  - `Cout` ← final byte carry.
  - `ovf` ← (opA[MSB] == opB[MSB]) && (S[MSB] != opA[MSB]), using the inverted B for subtract.
  - `zero` ← (S == 0).
- `S`, `Cout`, `ovf` and `zero` hold their values until the next completion. They never show partial results.
- `start` during RUN is ignored; it is not queued.
- Subtract semantics: `Cout`=1 means no borrow (A ≥ B unsigned).

## Timing
- Reset values (asynchronous, take effect immediately):
  - State = IDLE.
  - `busy`=0, `done`=0.
  - `S`=0, `Cout`=0, `ovf`=0, `zero`=0.
  - Internal registers are cleared.
- Latency: with `start` accepted at edge E0, bytes 0..NBYTES−1 are processed at edges E1..E_NBYTES.
  - `done`=1 during the cycle after E_NBYTES: 4 cycles after the start edge for the default configuration.
  - Outputs are valid in that same cycle.
- `busy`=1 from after E0 through E_NBYTES; it is 0 in the DONE cycle.
- `done` is high for exactly one cycle.
- Throughput: back-to-back starts complete one operation every NBYTES+1 cycles.
- `rst_n` asserted mid-RUN aborts the operation:
  - Outputs return to their reset values.
  - No `done` pulse is produced.
- Operand inputs only need to be stable at the accepting edge.

## Structure
- Shared package `alu_seq_pkg`:
  - State encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - `BYTE_W`=8.
- One sub-module: the existing `CLA_8bit`, instantiated once. The byte mux feeding it and the accumulator write logic stay in this module.

## Test plan
- Reset, then A=32'h000000a5, B=32'h0000005a, Cin=0, sub=0, start pulse → `done` 4 cycles later; S=32'h000000ff, Cout=0, ovf=0, zero=0.
- Full carry chain: A=32'hffffffff, B=32'h00000001, Cin=0 → S=32'h00000000, Cout=1, zero=1, ovf=0.
- Subtract: A=5, B=7, sub=1, Cin=1 (ignored) → S=32'hfffffffe, Cout=0, ovf=0. Then A=7, B=5 → S=2, Cout=1.
- Signed overflow: A=32'h7fffffff, B=32'h00000001 → S=32'h80000000, ovf=1, Cout=0. Cin=1 with A=B=32'h000000f1/32'h0000001f → S=32'h00000111.
- Handshake:
  - `start` re-asserted during RUN is ignored; `done` pulses once.
  - `start` held high through DONE launches a back-to-back operation; `busy` rises in the following cycle.
  - Results hold stable between operations.
- Reset mid-op: pull `rst_n` low at E2 → all outputs are 0 immediately and no `done` pulse appears. After release, a new start completes normally.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU datapath: FSM state encoding and byte width.
package alu_seq_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cla_seq_adder32_cla8.sv
// 8-bit carry-lookahead adder slice; every carry is a flat sum of generate/propagate products.
module CLA_8bit (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  output logic [7:0] S,
  output logic       Cout,
  output logic       PG,
  output logic       GG
);

  logic [7:0] gen;
  logic [7:0] prop;
  logic [8:0] carry;
  logic       pChain;
  logic       groupGen;

  assign gen  = A & B;
  assign prop = A ^ B;

  // Carry i+1 = g[i] | p[i]g[i-1] | ... | p[i..0]Cin, expanded term by term.
  always_comb begin
    carry    = '0;
    pChain   = 1'b1;
    groupGen = 1'b0;
    carry[0] = Cin;
    for (int i = 0; i < 8; i++) begin
      pChain = 1'b1;
      for (int j = i; j >= 0; j--) begin
        carry[i+1] = carry[i+1] | (pChain & gen[j]);
        pChain     = pChain & prop[j];
      end
      if (i == 7) groupGen = carry[i+1];
      carry[i+1] = carry[i+1] | (pChain & Cin);
    end
  end

  assign S    = prop ^ carry[7:0];
  assign Cout = carry[8];
  assign PG   = &prop;
  assign GG   = groupGen;

endmodule

// File: rtl/cla_seq_adder32.sv
// Multi-cycle add/subtract unit: one shared CLA_8bit slice, one byte per clock, LSB first,
// with a start/busy/done handshake and registered S/Cout/ovf/zero results.
module cla_seq_adder32
  import alu_seq_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NBYTES = WIDTH / BYTE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             ovf,
  output logic             zero
);

  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opA_q, opA_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic              accept;
  logic [BYTE_W-1:0] byteA, byteB, byteSum;
  logic              byteCout, claPg, claGg;
  logic              unused_ok;

  assign byteA = opA_q[idx_q*BYTE_W +: BYTE_W];
  assign byteB = opB_q[idx_q*BYTE_W +: BYTE_W];

  CLA_8bit u_cla (
    .A    (byteA),
    .B    (byteB),
    .Cin  (carry_q),
    .S    (byteSum),
    .Cout (byteCout),
    .PG   (claPg),
    .GG   (claGg)
  );

  assign unused_ok = &{1'b0, claPg, claGg};

  assign accept = start && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d = state_q;
    opA_d   = opA_q;
    opB_d   = opB_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        acc_d[idx_q*BYTE_W +: BYTE_W] = byteSum;
        carry_d = byteCout;
        idx_d   = idx_q + 1'b1;
        // Results are published only on the final byte so S never shows a partial sum.
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          idx_d   = '0;
          sum_d   = acc_d;
          cout_d  = byteCout;
          ovf_d   = (opA_q[WIDTH-1] == opB_q[WIDTH-1]) && (acc_d[WIDTH-1] != opA_q[WIDTH-1]);
          zero_d  = (acc_d == '0);
        end
      end
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      opA_d   = A;
      opB_d   = B ^ {WIDTH{sub}};
      carry_d = sub ? 1'b1 : Cin;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opA_q   <= '0;
      opB_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      opA_q   <= opA_d;
      opB_q   <= opB_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign S    = sum_q;
  assign Cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_cla_seq_adder32.sv
// Randomized self-checking bench for cla_seq_adder32 against a signed/unsigned arithmetic model.
module tb_cla_seq_adder32;

  localparam int NB = 4;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        rst_n, start, Cin, sub;
  logic [31:0] A, B, S;
  logic        busy, done, Cout, ovf, zero;

  int checkCount = 0;
  int passCount  = 0;

  logic [31:0] expS, prevS;
  logic        expCout, expOvf, expZero;
  logic        prevCout, prevOvf, prevZero;

  cla_seq_adder32 #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .sub   (sub),
    .busy  (busy),
    .done  (done),
    .S     (S),
    .Cout  (Cout),
    .ovf   (ovf),
    .zero  (zero)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  // Drive one request at a negedge; the reference result comes from plain integer arithmetic.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic sm);
    longint sa, sbv, r, ua, ub, ur;
    sa = $signed(a);
    sbv = $signed(b);
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    if (sm) begin
      r       = sa - sbv;
      expCout = (ua >= ub);
    end else begin
      r       = sa + sbv + longint'(ci);
      ur      = ua + ub + longint'(ci);
      expCout = ((ur >> 32) != 0);
    end
    expS    = r[31:0];
    expOvf  = (r > SMAX) || (r < SMIN);
    expZero = (expS == 32'h0);
    A = a; B = b; Cin = ci; sub = sm; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = $urandom; B = $urandom; Cin = 1'($urandom); sub = 1'($urandom);
  endtask

  task automatic waitDone(input bit pokeStart);
    for (int k = 1; k <= NB; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k < NB) begin
        checkOutput("busyRun", busy, 1);
        checkOutput("doneEarly", done, 0);
        checkOutput("holdS", S, prevS);
      end else begin
        checkOutput("donePulse", done, 1);
        checkOutput("busyInDone", busy, 0);
        checkOutput("S", S, expS);
        checkOutput("Cout", Cout, expCout);
        checkOutput("ovf", ovf, expOvf);
        checkOutput("zero", zero, expZero);
        prevS = expS; prevCout = expCout; prevOvf = expOvf; prevZero = expZero;
      end
      if (pokeStart && k == 1) start = 1'b1;
      if (pokeStart && k == 2) start = 1'b0;
    end
  endtask

  task automatic idleCycle();
    @(posedge clk);
    @(negedge clk);
    checkOutput("doneOnce", done, 0);
    checkOutput("busyIdle", busy, 0);
    checkOutput("holdSIdle", S, prevS);
    checkOutput("holdCout", Cout, prevCout);
    checkOutput("holdOvf", ovf, prevOvf);
    checkOutput("holdZero", zero, prevZero);
  endtask

  task automatic resetMidOp();
    applyStimulus(32'h12345678, 32'h0badf00d, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rstS", S, 0);
    checkOutput("rstCout", Cout, 0);
    checkOutput("rstOvf", ovf, 0);
    checkOutput("rstZero", zero, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", done, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("noDoneInRst", done, 0);
    end
    rst_n = 1'b1;
    prevS = '0; prevCout = 1'b0; prevOvf = 1'b0; prevZero = 1'b0;
    for (int k = 0; k < NB + 1; k++) begin
      @(negedge clk);
      checkOutput("noDoneAfterRst", done, 0);
      checkOutput("idleAfterRst", busy, 0);
    end
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 32'hffffffff;
      1:       return 32'h80000000;
      2:       return 32'h7fffffff;
      3:       return 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Cin = 1'b0; sub = 1'b0;
    prevS = '0; prevCout = 1'b0; prevOvf = 1'b0; prevZero = 1'b0;
    #12;
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetDone", done, 0);
    checkOutput("resetS", S, 0);
    checkOutput("resetCout", Cout, 0);
    checkOutput("resetOvf", ovf, 0);
    checkOutput("resetZero", zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(32'h000000a5, 32'h0000005a, 1'b0, 1'b0); waitDone(0); idleCycle();
    applyStimulus(32'hffffffff, 32'h00000001, 1'b0, 1'b0); waitDone(0); idleCycle();
    applyStimulus(32'd5, 32'd7, 1'b1, 1'b1);               waitDone(0); idleCycle();
    applyStimulus(32'd7, 32'd5, 1'b0, 1'b1);               waitDone(0); idleCycle();
    applyStimulus(32'h7fffffff, 32'h00000001, 1'b0, 1'b0); waitDone(0); idleCycle();
    applyStimulus(32'h000000f1, 32'h0000001f, 1'b1, 1'b0); waitDone(0); idleCycle();

    applyStimulus(32'h00010000, 32'h0000ffff, 1'b0, 1'b0); waitDone(1); idleCycle();

    applyStimulus(32'hdeadbeef, 32'h01010101, 1'b1, 1'b0); waitDone(0);
    applyStimulus(32'h80000000, 32'h00000001, 1'b0, 1'b1); waitDone(0); idleCycle();

    resetMidOp();
    applyStimulus(32'h00000003, 32'h00000003, 1'b0, 1'b1); waitDone(0); idleCycle();

    for (int n = 0; n < 40; n++) begin
      applyStimulus(pickOperand(), pickOperand(), 1'($urandom), 1'($urandom));
      waitDone(1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) != 0) idleCycle();
    end
    idleCycle();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
